// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared types and constants for the instruction-memory responder
package imem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;
  localparam int          CNT_W    = 4;

endpackage

// File: rtl/imem_array.sv
// rtl/imem_array.sv - word storage with synchronous write and asynchronous read
// Contents are deliberately not reset so program images survive a core reset.
module imem_array
  import imem_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10,
  parameter int WIDTH      = 32
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [DEPTH_LOG2-1:0] waddr_i,
  input  logic [WIDTH-1:0]      wdata_i,
  input  logic [DEPTH_LOG2-1:0] raddr_i,
  output logic [WIDTH-1:0]      rdata_o
);

  logic [WIDTH-1:0] mem_q [2**DEPTH_LOG2];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/imem_responder.sv
// rtl/imem_responder.sv - fetch-port responder returning instruction words after a fixed latency
// Optional IMEM_ACCESS_CHECK_EN adds misalignment/range faults and drops out-of-range writes.
module imem_responder
  import imem_pkg::*;
#(
  parameter int          DATA_LEN   = 32,
  parameter int          DEPTH_LOG2 = 10,
  parameter logic [31:0] ADDR_BASE  = 32'h8000_0000,
  parameter int          LATENCY    = 1
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [DATA_LEN-1:0] req_addr,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [DATA_LEN-1:0] resp_inst,
  output logic                resp_err,
  input  logic                wr_en,
  input  logic [DATA_LEN-1:0] wr_addr,
  input  logic [DATA_LEN-1:0] wr_data
);

  state_e              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [DATA_LEN-1:0] addr_q;
  logic [DATA_LEN-1:0] inst_q;
  logic                err_q;
  logic                req_ready_q;
  logic                resp_valid_q;

  logic [DEPTH_LOG2-1:0] rd_idx;
  logic [DEPTH_LOG2-1:0] wr_idx;
  logic [DATA_LEN-1:0]   rd_data;
  logic                  rd_fault;
  logic                  wr_keep;

  // Offsets wrap in 32 bits; the word index is the offset's word number modulo the depth.
  assign rd_idx = DEPTH_LOG2'((addr_q - ADDR_BASE) >> 2);
  assign wr_idx = DEPTH_LOG2'((wr_addr - ADDR_BASE) >> 2);

`ifdef IMEM_ACCESS_CHECK_EN
  localparam logic [DATA_LEN-1:0] SPAN = DATA_LEN'(4) << DEPTH_LOG2;

  logic [DATA_LEN-1:0] rd_off;
  logic [DATA_LEN-1:0] wr_off;

  assign rd_off   = addr_q - ADDR_BASE;
  assign wr_off   = wr_addr - ADDR_BASE;
  assign rd_fault = (addr_q[1:0] != 2'b00) || (rd_off >= SPAN);
  assign wr_keep  = wr_en && (wr_off < SPAN);
`else
  assign rd_fault = 1'b0;
  assign wr_keep  = wr_en;
`endif

  imem_array #(
    .DEPTH_LOG2(DEPTH_LOG2),
    .WIDTH     (DATA_LEN)
  ) u_array (
    .clk_i  (sys_clk),
    .we_i   (wr_keep),
    .waddr_i(wr_idx),
    .wdata_i(wr_data),
    .raddr_i(rd_idx),
    .rdata_o(rd_data)
  );

  // Sampling at the WAIT->RESP edge reads the array before a same-edge write lands.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      addr_q       <= '0;
      inst_q       <= '0;
      err_q        <= 1'b0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            addr_q      <= req_addr;
            cnt_q       <= CNT_W'(LATENCY - 1);
            req_ready_q <= 1'b0;
            state_q     <= WAIT;
          end
        end
        WAIT: begin
          if (cnt_q == '0) begin
            inst_q       <= rd_fault ? NOP_INST : rd_data;
            err_q        <= rd_fault;
            resp_valid_q <= 1'b1;
            state_q      <= RESP;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
            state_q      <= IDLE;
          end
        end
        default: begin
          state_q      <= IDLE;
          req_ready_q  <= 1'b1;
          resp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_inst  = inst_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_imem_responder.sv
// tb/tb_imem_responder.sv - directed self-checking bench for imem_responder (LATENCY 1 and 3)
`timescale 1ns/1ps
module tb_imem_responder;

    int total  = 0;
    int passed = 0;
    int failed = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs === exp) begin
            passed++;
        end else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        a_req_valid = 0, a_req_ready, a_resp_valid, a_resp_ready = 0, a_resp_err, a_wr_en = 0;
    logic [31:0] a_req_addr = 0, a_resp_inst, a_wr_addr = 0, a_wr_data = 0;
    logic        b_req_valid = 0, b_req_ready, b_resp_valid, b_resp_ready = 0, b_resp_err, b_wr_en = 0;
    logic [31:0] b_req_addr = 0, b_resp_inst, b_wr_addr = 0, b_wr_data = 0;

    imem_responder #(.DATA_LEN(32), .DEPTH_LOG2(10), .ADDR_BASE(32'h8000_0000), .LATENCY(1)) u_a (
        .sys_clk(clk), .sys_rst_n(rst_n),
        .req_valid(a_req_valid), .req_ready(a_req_ready), .req_addr(a_req_addr),
        .resp_valid(a_resp_valid), .resp_ready(a_resp_ready), .resp_inst(a_resp_inst), .resp_err(a_resp_err),
        .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data)
    );

    imem_responder #(.DATA_LEN(32), .DEPTH_LOG2(10), .ADDR_BASE(32'h8000_0000), .LATENCY(3)) u_b (
        .sys_clk(clk), .sys_rst_n(rst_n),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_addr(b_req_addr),
        .resp_valid(b_resp_valid), .resp_ready(b_resp_ready), .resp_inst(b_resp_inst), .resp_err(b_resp_err),
        .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_b(input logic [31:0] addr, input logic [31:0] data);
        b_wr_en   = 1'b1;
        b_wr_addr = addr;
        b_wr_data = data;
        tick();
        b_wr_en   = 1'b0;
    endtask

    task automatic fetch_b(input logic [31:0] addr, input logic [31:0] exp_inst,
                           input logic exp_err, input string tag);
        int n;
        b_req_addr  = addr;
        b_req_valid = 1'b1;
        chk({tag, ".ready"}, b_req_ready, 1'b1);
        tick();
        b_req_valid = 1'b0;
        n = 0;
        while (!b_resp_valid && n < 20) begin
            tick();
            n++;
        end
        chk({tag, ".latency"}, n, 3);
        chk({tag, ".inst"}, b_resp_inst, exp_inst);
        chk({tag, ".err"}, b_resp_err, exp_err);
        b_resp_ready = 1'b1;
        tick();
        b_resp_ready = 1'b0;
        chk({tag, ".done_ready"}, b_req_ready, 1'b1);
        chk({tag, ".done_valid"}, b_resp_valid, 1'b0);
    endtask

    initial begin
        tick();
        tick();
        chk("rst.a_ready", a_req_ready, 1'b1);
        chk("rst.a_valid", a_resp_valid, 1'b0);
        chk("rst.a_inst", a_resp_inst, 32'h0);
        chk("rst.a_err", a_resp_err, 1'b0);
        chk("rst.b_ready", b_req_ready, 1'b1);
        chk("rst.b_valid", b_resp_valid, 1'b0);
        rst_n = 1'b1;
        tick();

        a_wr_en = 1'b1; a_wr_addr = 32'h8000_0000; a_wr_data = 32'h0010_0093;
        tick();
        a_wr_en = 1'b0;
        a_req_valid = 1'b1; a_req_addr = 32'h8000_0000;
        tick();
        a_req_valid = 1'b0;
        chk("l1.busy_ready", a_req_ready, 1'b0);
        chk("l1.not_yet_valid", a_resp_valid, 1'b0);
        tick();
        chk("l1.valid", a_resp_valid, 1'b1);
        chk("l1.inst", a_resp_inst, 32'h0010_0093);
        chk("l1.err", a_resp_err, 1'b0);
        a_resp_ready = 1'b1;
        tick();
        a_resp_ready = 1'b0;
        chk("l1.after_ready", a_req_ready, 1'b1);
        chk("l1.after_valid", a_resp_valid, 1'b0);

        wr_b(32'h8000_0000, 32'h1111_1111);
        wr_b(32'h8000_0004, 32'h2222_2222);
        b_req_valid = 1'b1; b_req_addr = 32'h8000_0004;
        tick();
        b_req_valid = 1'b0; b_req_addr = 32'h8000_0000;
        tick();
        chk("bp.wait1_valid", b_resp_valid, 1'b0);
        tick();
        chk("bp.wait2_valid", b_resp_valid, 1'b0);
        tick();
        chk("bp.valid", b_resp_valid, 1'b1);
        chk("bp.inst", b_resp_inst, 32'h2222_2222);
        b_req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp.hold_valid", b_resp_valid, 1'b1);
            chk("bp.hold_inst", b_resp_inst, 32'h2222_2222);
            chk("bp.hold_ready", b_req_ready, 1'b0);
        end
        b_req_valid  = 1'b0;
        b_resp_ready = 1'b1;
        tick();
        b_resp_ready = 1'b0;
        chk("bp.release_ready", b_req_ready, 1'b1);
        chk("bp.release_valid", b_resp_valid, 1'b0);
        tick();

        b_req_valid = 1'b1; b_req_addr = 32'h8000_0000;
        tick();
        b_req_valid = 1'b0;
        tick();
        tick();
        b_wr_en = 1'b1; b_wr_addr = 32'h8000_0000; b_wr_data = 32'hDEAD_BEEF;
        tick();
        b_wr_en = 1'b0;
        chk("haz.valid", b_resp_valid, 1'b1);
        chk("haz.old_inst", b_resp_inst, 32'h1111_1111);
        tick();
        chk("haz.held_inst", b_resp_inst, 32'h1111_1111);
        b_resp_ready = 1'b1;
        tick();
        b_resp_ready = 1'b0;
        fetch_b(32'h8000_0000, 32'hDEAD_BEEF, 1'b0, "haz.refetch");

`ifdef IMEM_ACCESS_CHECK_EN
        fetch_b(32'h8000_0002, 32'h0000_0013, 1'b1, "chk.misalign");
        fetch_b(32'h8000_1000, 32'h0000_0013, 1'b1, "chk.range");
        wr_b(32'h8000_1000, 32'h5555_5555);
        fetch_b(32'h8000_0000, 32'hDEAD_BEEF, 1'b0, "chk.drop_write");
`else
        fetch_b(32'h8000_1000, 32'hDEAD_BEEF, 1'b0, "nochk.wrap");
        fetch_b(32'h8000_0002, 32'hDEAD_BEEF, 1'b0, "nochk.lowbits");
        wr_b(32'h8000_1004, 32'h0BAD_F00D);
        fetch_b(32'h8000_0004, 32'h0BAD_F00D, 1'b0, "nochk.wrap_write");
`endif

        b_req_valid = 1'b1; b_req_addr = 32'h8000_0004;
        tick();
        b_req_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        chk("rstw.ready", b_req_ready, 1'b1);
        chk("rstw.valid", b_resp_valid, 1'b0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rstw.no_resp", b_resp_valid, 1'b0);
        end
        fetch_b(32'h8000_0000, 32'hDEAD_BEEF, 1'b0, "rstw.next");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
